// File: rtl/alu_req_scheduler_pkg.sv
// Shared types and defaults for the ALU request scheduler: FSM states,
// opcode encodings and default operand/opcode/result widths.
package alu_sched_pkg;

    localparam int AW_DEF      = 3;
    localparam int OW_DEF      = 2;
    localparam int RW_DEF      = 6;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

endpackage

// File: rtl/alu_req_scheduler_if.sv
// Bundle of requester, ALU and response signals around the scheduler.
// slave = scheduler side, master = requesters/ALU/consumer side.
interface alu_req_scheduler_if
    import alu_sched_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int OW = OW_DEF,
    parameter int RW = RW_DEF
);
    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_a;
    logic [AW-1:0] req0_b;
    logic [OW-1:0] req0_op;
    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_a;
    logic [AW-1:0] req1_b;
    logic [OW-1:0] req1_op;
    logic [AW-1:0] alu_portA;
    logic [AW-1:0] alu_portB;
    logic [OW-1:0] alu_opcode;
    logic          alu_init;
    logic          alu_done;
    logic [RW-1:0] alu_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [RW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_done, alu_result, rsp_ready,
        output req0_ready, req1_ready,
        output alu_portA, alu_portB, alu_opcode, alu_init,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_done, alu_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_portA, alu_portB, alu_opcode, alu_init,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

endinterface

// File: rtl/alu_req_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the priority pointer moves past the winner
// only when the grant is actually accepted.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    input  logic accept_i,
    output logic gnt_vld_o,
    output logic gnt_id_o
);
    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic prio_q;

    always_comb begin
        gnt_vld_o = req0_i | req1_i;
        gnt_id_o  = (req0_i & req1_i) ? prio_q : req1_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q <= 1'b0;
        end else if (accept_i) begin
            prio_q <= ~gnt_id_o;
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU between two requesters: round-robin accept, start pulse, wait for done, valid/ready response.
// Optional WAIT-state abort enabled by defining ALU_SCHED_TIMEOUT_EN.
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int OW      = OW_DEF,
    parameter int RW      = RW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    alu_req_scheduler_if.slave bus
);
    state_e        state_q;
    logic [AW-1:0] a_q, b_q, a_d, b_d;
    logic [OW-1:0] op_q, op_d;
    logic          id_q;
    logic          init_q;
    logic          rsp_valid_q;
    logic [RW-1:0] data_q;
    logic          err_q;
    logic          busy_q;
    logic          gnt_vld, gnt_id, accept, tmo;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req0_i    (bus.req0_valid),
        .req1_i    (bus.req1_valid),
        .accept_i  (accept),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    always_comb begin
        accept         = (state_q == IDLE) && gnt_vld;
        bus.req0_ready = accept && !gnt_id;
        bus.req1_ready = accept &&  gnt_id;
        a_d            = gnt_id ? bus.req1_a  : bus.req0_a;
        b_d            = gnt_id ? bus.req1_b  : bus.req0_b;
        op_d           = gnt_id ? bus.req1_op : bus.req0_op;
    end

`ifdef ALU_SCHED_TIMEOUT_EN
    logic [3:0] wcnt_q;

    // Cleared while issuing so the first WAIT cycle sees zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q <= 4'd0;
        end else if (state_q == ISSUE) begin
            wcnt_q <= 4'd0;
        end else if (state_q == WAIT) begin
            wcnt_q <= wcnt_q + 4'd1;
        end
    end

    assign tmo = (wcnt_q == 4'(TIMEOUT - 1));
`else
    // Without the counter WAIT never gives up; TIMEOUT has no effect.
    assign tmo = 1'b0 && (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            init_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            init_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        op_q    <= op_d;
                        id_q    <= gnt_id;
                        init_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    // done has priority over a timeout in the same cycle
                    if (bus.alu_done) begin
                        data_q      <= bus.alu_result;
                        err_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (tmo) begin
                        data_q      <= '1;
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_portA  = a_q;
    assign bus.alu_portB  = b_q;
    assign bus.alu_opcode = op_q;
    assign bus.alu_init   = init_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = busy_q;

endmodule
